video_out_stage: RTL and testbench



---
 rtl/video_out_stage.sv | 129 ++++++++++++
 tb/tb_video_out_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/video_out_stage.sv
// =============================================================================
// Module   : video_out_stage
// Brief    : M92 video timing counters, sync/blank alignment, RGB expansion
//            and vblank/raster interrupt pulses.
// Revision : 1.0
// =============================================================================
`default_nettype none

module video_out_stage #(
    parameter int H_ACTIVE   = 320,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 32,
    parameter int H_BP       = 56,
    parameter int V_ACTIVE   = 240,
    parameter int V_FP       = 8,
    parameter int V_SYNC     = 3,
    parameter int V_BP       = 11,
    parameter int PIPE_DELAY = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce_pix,
    input  logic [8:0] raster_line,
    input  logic [4:0] red_in,
    input  logic [4:0] green_in,
    input  logic [4:0] blue_in,
    output logic [8:0] hcount,
    output logic [8:0] vcount,
    output logic       hblank,
    output logic       vblank,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       vblank_irq,
    output logic       raster_irq
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [8:0] c_h_last     = 9'(H_TOTAL - 1);
    localparam logic [8:0] c_v_last     = 9'(V_TOTAL - 1);
    localparam logic [8:0] c_h_active   = 9'(H_ACTIVE);
    localparam logic [8:0] c_v_active   = 9'(V_ACTIVE);
    localparam logic [8:0] c_hs_start   = 9'(H_ACTIVE + H_FP);
    localparam logic [8:0] c_hs_end     = 9'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [8:0] c_vs_start   = 9'(V_ACTIVE + V_FP);
    localparam logic [8:0] c_vs_end     = 9'(V_ACTIVE + V_FP + V_SYNC);
    // Delay-line word is {hblank, vblank, hsync, vsync}; idles blanked, sync low.
    localparam logic [3:0] c_dly_reset  = 4'b1100;

    logic       w_h_wrap;
    logic       w_v_wrap;
    logic [8:0] w_hcount_nxt;
    logic [8:0] w_vcount_nxt;
    logic [3:0] w_timing_raw;
    logic       w_blank;
    logic [3:0] r_dly [PIPE_DELAY];

    function automatic logic [7:0] expand(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    always_comb begin
        w_h_wrap     = (hcount == c_h_last);
        w_v_wrap     = (vcount == c_v_last);
        w_hcount_nxt = w_h_wrap ? 9'd0 : hcount + 9'd1;
        w_vcount_nxt = vcount;
        if (w_h_wrap) begin
            w_vcount_nxt = w_v_wrap ? 9'd0 : vcount + 9'd1;
        end
        w_timing_raw = {hcount >= c_h_active,
                        vcount >= c_v_active,
                        (hcount >= c_hs_start) && (hcount < c_hs_end),
                        (vcount >= c_vs_start) && (vcount < c_vs_end)};
        w_blank      = r_dly[PIPE_DELAY-1][3] | r_dly[PIPE_DELAY-1][2];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcount     <= 9'd0;
            vcount     <= 9'd0;
            vblank_irq <= 1'b0;
            raster_irq <= 1'b0;
        end else if (ce_pix) begin
            hcount     <= w_hcount_nxt;
            vcount     <= w_vcount_nxt;
            // Pulses mark the step onto the line, so they look at the next count.
            vblank_irq <= (w_hcount_nxt == 9'd0) && (w_vcount_nxt == c_v_active);
            raster_irq <= (w_hcount_nxt == 9'd0) && (w_vcount_nxt == raster_line);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PIPE_DELAY; i++) begin
                r_dly[i] <= c_dly_reset;
            end
        end else if (ce_pix) begin
            r_dly[0] <= w_timing_raw;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    // Final stage lines the delayed timing up with the palette colour arriving now.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hblank <= 1'b1;
            vblank <= 1'b1;
            hsync  <= 1'b0;
            vsync  <= 1'b0;
            red    <= 8'h00;
            green  <= 8'h00;
            blue   <= 8'h00;
        end else if (ce_pix) begin
            {hblank, vblank, hsync, vsync} <= r_dly[PIPE_DELAY-1];
            red    <= w_blank ? 8'h00 : expand(red_in);
            green  <= w_blank ? 8'h00 : expand(green_in);
            blue   <= w_blank ? 8'h00 : expand(blue_in);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_video_out_stage.sv
// =============================================================================
// Module   : tb_video_out_stage
// Brief    : Directed self-checking bench for video_out_stage on a reduced
//            25x17 raster (16x10 active, hsync at 18..21, vsync lines 12..14).
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_video_out_stage;

    localparam int FRAME = 425;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ce_pix;
    logic [8:0] raster_line;
    logic [4:0] red_in, green_in, blue_in;
    logic [8:0] hcount, vcount;
    logic       hblank, vblank, hsync, vsync;
    logic [7:0] red, green, blue;
    logic       vblank_irq, raster_irq;

    int n_total = 0;
    int n_bad   = 0;
    int ce_div  = 1;

    int st_unblank, st_badcol, st_hsync, st_vsync, st_hwrap, st_vwrap;
    int st_hmax, st_vmax, st_vb_cnt, st_vb_step, st_rs_cnt, st_rs_step;
    int st_hs_rise, st_vs_rise, st_hb_rise, clk_vb, clk_rs;
    logic [7:0] st_red18, st_red19;

    video_out_stage #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
        .PIPE_DELAY(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix),
        .raster_line(raster_line),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .hcount(hcount), .vcount(vcount),
        .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .vblank_irq(vblank_irq), .raster_irq(raster_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One ce_pix step: ce_div-1 idle clocks then one enabled clock; samples at negedge.
    task automatic step();
        for (int i = 0; i < ce_div; i++) begin
            ce_pix = (i == ce_div - 1);
            @(negedge clk);
            if (vblank_irq) clk_vb++;
            if (raster_irq) clk_rs++;
        end
    endtask

    task automatic run_frame();
        logic [8:0] ph, pv;
        logic phs, pvs, phb;
        st_unblank = 0; st_badcol = 0; st_hsync = 0; st_vsync = 0;
        st_hwrap = 0; st_vwrap = 0; st_hmax = 0; st_vmax = 0;
        st_vb_cnt = 0; st_vb_step = -1; st_rs_cnt = 0; st_rs_step = -1;
        st_hs_rise = -1; st_vs_rise = -1; st_hb_rise = -1;
        clk_vb = 0; clk_rs = 0;
        ph = hcount; pv = vcount; phs = hsync; pvs = vsync; phb = hblank;
        for (int s = 1; s <= FRAME; s++) begin
            step();
            if (!hblank && !vblank) begin
                st_unblank++;
                if ({red, green, blue} !== 24'hFF8400) st_badcol++;
            end else if ({red, green, blue} !== 24'h000000) begin
                st_badcol++;
            end
            if (hsync) st_hsync++;
            if (vsync) st_vsync++;
            if (hsync && !phs && st_hs_rise < 0) st_hs_rise = s;
            if (vsync && !pvs && st_vs_rise < 0) st_vs_rise = s;
            if (hblank && !phb && st_hb_rise < 0) st_hb_rise = s;
            if (s == 18) st_red18 = red;
            if (s == 19) st_red19 = red;
            if (ph == 9'd24 && hcount == 9'd0) st_hwrap++;
            if (pv == 9'd16 && vcount == 9'd0) st_vwrap++;
            if (int'(hcount) > st_hmax) st_hmax = int'(hcount);
            if (int'(vcount) > st_vmax) st_vmax = int'(vcount);
            if (vblank_irq) begin st_vb_cnt++; st_vb_step = s; end
            if (raster_irq) begin st_rs_cnt++; st_rs_step = s; end
            ph = hcount; pv = vcount; phs = hsync; pvs = vsync; phb = hblank;
        end
    endtask

    task automatic check_frame(input string tag, input int irq_w);
        check({tag, " unblanked"}, st_unblank, 160);
        check({tag, " colour"}, st_badcol, 0);
        check({tag, " hsync steps"}, st_hsync, 68);
        check({tag, " vsync steps"}, st_vsync, 75);
        check({tag, " hsync rise"}, st_hs_rise, 21);
        check({tag, " vsync rise"}, st_vs_rise, 303);
        check({tag, " vblank_irq count"}, st_vb_cnt, 1);
        check({tag, " vblank_irq step"}, st_vb_step, 250);
        check({tag, " vblank_irq clocks"}, clk_vb, irq_w);
        check({tag, " end hcount"}, hcount, 0);
        check({tag, " end vcount"}, vcount, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " hcount"}, hcount, 0);
        check({tag, " vcount"}, vcount, 0);
        check({tag, " blank"}, {hblank, vblank}, 2'b11);
        check({tag, " sync"}, {hsync, vsync}, 2'b00);
        check({tag, " rgb"}, {red, green, blue}, 24'h0);
        check({tag, " irqs"}, {vblank_irq, raster_irq}, 2'b00);
    endtask

    initial begin
        reset_n = 1'b0; ce_pix = 1'b0; raster_line = 9'd4;
        red_in = 5'h1F; green_in = 5'h10; blue_in = 5'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Frame 1: ce always high, raster on line 4.
        run_frame();
        check_frame("f1", 1);
        check("f1 hwraps", st_hwrap, 17);
        check("f1 vwraps", st_vwrap, 1);
        check("f1 hmax", st_hmax, 24);
        check("f1 vmax", st_vmax, 16);
        check("f1 hblank rise", st_hb_rise, 19);
        check("f1 red before hblank", st_red18, 8'hFF);
        check("f1 red at hblank", st_red19, 8'h00);
        check("f1 raster count", st_rs_cnt, 1);
        check("f1 raster step", st_rs_step, 100);

        // Frame 2: raster on the first vblank line coincides with vblank_irq.
        raster_line = 9'd10;
        run_frame();
        check_frame("f2", 1);
        check("f2 raster count", st_rs_cnt, 1);
        check("f2 raster step", st_rs_step, 250);

        // Frame 3: raster_line equal to V_TOTAL never matches.
        raster_line = 9'd17;
        run_frame();
        check("f3 raster count", st_rs_cnt, 0);

        // Frame 4: ce every 4th clock, raster on last line inside vblank.
        raster_line = 9'd16;
        ce_div = 4;
        run_frame();
        check_frame("f4", 4);
        check("f4 raster count", st_rs_cnt, 1);
        check("f4 raster step", st_rs_step, 400);
        check("f4 raster clocks", clk_rs, 4);

        // Mid-frame asynchronous reset at line 6, pixel 8.
        ce_div = 1;
        raster_line = 9'd300;
        for (int s = 0; s < 158; s++) step();
        check("mid hcount", hcount, 8);
        check("mid vcount", vcount, 6);
        check("mid blank", {hblank, vblank}, 2'b00);
        check("mid red", red, 8'hFF);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run_frame();
        check_frame("f5", 1);
        check("f5 raster 300 count", st_rs_cnt, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
